// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared defaults and helpers for the parametrised pipelined FIR (fir_param_pipe).
//   - TAPS/DW/CW/FRAC defaults (16 taps, Q1.15 samples and coefficients)
//   - tree_levels/acc_width/latency derive L, AW and LAT from the parameters
//   - sat_to_dw/sat_hit clip a scaled accumulator to a DW-bit signed range
package fir_pkg;

  localparam int TAPS_DEF = 16;
  localparam int DW_DEF   = 16;
  localparam int CW_DEF   = 16;
  localparam int FRAC_DEF = 15;

  // Number of adder-tree levels; the leaf count is padded up to 2**L.
  function automatic int tree_levels(input int taps);
    return $clog2(taps);
  endfunction

  // Full-precision accumulator width; the tree cannot overflow this.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Input-sample register to output register count.
  function automatic int latency(input int taps);
    return 3 + $clog2(taps);
  endfunction

  // Clip a signed value to the range of a dw-bit two's complement number.
  function automatic longint sat_to_dw(input longint s, input int dw);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end else begin
      return s;
    end
  endfunction

  // True when sat_to_dw would have to clip s.
  function automatic logic sat_hit(input longint s, input int dw);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return (s > hi) || (s < lo);
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree
//   Pipelined binary adder tree: LEAVES inputs of W bits (LEAVES = 2**L),
//   one registered level per stage, L stages total. The valid bit travels
//   alongside the data; flush clears the valid bits only.
// Ports
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous active-high reset (data and valids)
//   flush      in   1           synchronous clear of the in-flight valid bits
//   in_valid   in   1           leaves carry a valid set of products
//   leaves     in   LEAVES*W    packed signed leaves, leaf i at [i*W +: W]
//   out_valid  out  1           sum is valid (in_valid delayed by L)
//   sum        out  W+L         signed sum of all leaves
module fir_adder_tree #(
  parameter int LEAVES = 16,
  parameter int W      = 32,
  parameter int L      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [LEAVES*W-1:0] leaves,
  output logic                out_valid,
  output logic [W+L-1:0]      sum
);

  localparam int SW = W + L;

  // Heap layout: node 1 is the root, node n has children 2n and 2n+1.
  // Children with index >= LEAVES are the input leaves themselves.
  logic signed [SW-1:0] node_r [1:LEAVES-1];
  logic [L-1:0]         v_r;

  for (genvar n = 1; n < LEAVES; n++) begin : g_node
    if (2 * n >= LEAVES) begin : g_bottom
      // Bottom level: sign-extend two leaves and add.
      always_ff @(posedge clk) begin
        if (rst) begin
          node_r[n] <= '0;
        end else begin
          node_r[n] <= SW'($signed(leaves[(2*n-LEAVES)*W +: W]))
                     + SW'($signed(leaves[(2*n+1-LEAVES)*W +: W]));
        end
      end
    end else begin : g_inner
      // Inner level: add the two child nodes from the previous stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          node_r[n] <= '0;
        end else begin
          node_r[n] <= node_r[2*n] + node_r[2*n+1];
        end
      end
    end
  end

  // Valid shift register, one bit per tree level.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= '0;
    end else if (flush) begin
      v_r <= '0;
    end else begin
      v_r[0] <= in_valid;
      for (int i = 1; i < L; i++) begin
        v_r[i] <= v_r[i-1];
      end
    end
  end

  assign out_valid = v_r[L-1];
  assign sum       = node_r[1];

endmodule

// File: rtl/fir_param_pipe.sv
// fir_param_pipe
//   Parametrised pipelined direct-form FIR with runtime-loadable coefficients,
//   valid-qualified input stream (bubbles preserved 1:1), flush and saturation flag.
//   Pipeline: delay line -> product registers -> L-level adder tree -> scale/clip.
//   Latency from accepted input to out_valid is 3+L registers.
// Configuration
//   FIR_ROUND_EN  defined: round half up before the FRAC shift; undefined: truncate.
// Ports
//   clk        in   1             rising-edge clock
//   rst        in   1             synchronous active-high reset (coefs cleared too)
//   in_valid   in   1             x_in valid this cycle
//   x_in       in   DW            signed input sample
//   flush      in   1             clear delay line and in-flight valids, coefs kept
//   coef_wr    in   1             coefficient write strobe
//   coef_addr  in   clog2(TAPS)   tap index to write (>= TAPS ignored)
//   coef_data  in   CW            signed coefficient
//   out_valid  out  1             y_out valid this cycle
//   y_out      out  DW            signed filtered, saturated sample (holds when idle)
//   sat_flag   out  1             y_out was clipped
module fir_param_pipe
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DW-1:0]           x_in,
  input  logic                    flush,
  input  logic                    coef_wr,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_data,
  output logic                    out_valid,
  output logic [DW-1:0]           y_out,
  output logic                    sat_flag
);

  localparam int L      = tree_levels(TAPS);
  localparam int LEAVES = 1 << L;
  localparam int PW     = DW + CW;
  localparam int AW     = acc_width(DW, CW, TAPS);

`ifdef FIR_ROUND_EN
  // Half an output LSB, i.e. 2**(FRAC-1); zero when FRAC is zero.
  localparam logic signed [AW:0] RND = (AW+1)'(64'sd1 <<< FRAC) >>> 1;
`else
  localparam logic signed [AW:0] RND = '0;
`endif

  logic signed [DW-1:0] x_hist_r [TAPS];
  logic signed [CW-1:0] coef_r   [TAPS];
  logic                 v_hist_r;
  logic signed [PW-1:0] prod_r   [TAPS];
  logic                 v_prod_r;
  logic [LEAVES*PW-1:0] leaves_s;
  logic [AW-1:0]        acc_s;
  logic                 v_acc_s;

  logic signed [AW:0]   acc_ext_s;
  logic signed [AW:0]   scaled_s;
  longint               scaled_l_s;
  longint               clip_s;
  logic                 hit_s;
  logic [DW-1:0]        y_next_s;

  // Delay line: shifts only on accepted samples, emptied by flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < TAPS; i++) begin
        x_hist_r[i] <= '0;
      end
      v_hist_r <= 1'b0;
    end else begin
      v_hist_r <= in_valid;
      if (in_valid) begin
        x_hist_r[0] <= x_in;
        for (int i = 1; i < TAPS; i++) begin
          x_hist_r[i] <= x_hist_r[i-1];
        end
      end else begin
        for (int i = 0; i < TAPS; i++) begin
          x_hist_r[i] <= x_hist_r[i];
        end
      end
    end
  end

  // Coefficient registers; flush leaves them alone, rst beats a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_r[i] <= '0;
      end
    end else if (coef_wr && (int'(coef_addr) < TAPS)) begin
      coef_r[coef_addr] <= coef_data;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        coef_r[i] <= coef_r[i];
      end
    end
  end

  // Product stage: full-precision DW+CW products of the current delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        prod_r[i] <= '0;
      end
      v_prod_r <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        prod_r[i] <= PW'(x_hist_r[i]) * PW'(coef_r[i]);
      end
      v_prod_r <= flush ? 1'b0 : v_hist_r;
    end
  end

  // Pad the tree up to a power of two with zero leaves.
  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < TAPS) begin : g_tap
      assign leaves_s[i*PW +: PW] = prod_r[i];
    end else begin : g_pad
      assign leaves_s[i*PW +: PW] = '0;
    end
  end

  fir_adder_tree #(
    .LEAVES (LEAVES),
    .W      (PW),
    .L      (L)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (v_prod_r),
    .leaves    (leaves_s),
    .out_valid (v_acc_s),
    .sum       (acc_s)
  );

  // Scale by FRAC (optionally rounded) and clip to DW bits.
  always_comb begin
    acc_ext_s  = {acc_s[AW-1], acc_s};
    scaled_s   = (acc_ext_s + RND) >>> FRAC;
    scaled_l_s = longint'(scaled_s);
    clip_s     = sat_to_dw(scaled_l_s, DW);
    hit_s      = sat_hit(scaled_l_s, DW);
    y_next_s   = DW'(clip_s);
  end

  // Output register; y_out and sat_flag hold while no valid result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y_out     <= '0;
      sat_flag  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= v_acc_s;
      if (v_acc_s) begin
        y_out    <= y_next_s;
        sat_flag <= hit_s;
      end else begin
        y_out    <= y_out;
        sat_flag <= sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_fir_param_pipe.sv
// tb_fir_param_pipe
//   Self-checking bench for fir_param_pipe (TAPS=16, DW=CW=16, FRAC=15).
//   A behavioural model computes each accepted sample's output as a plain
//   dot product over its history and schedules it LAT-1 edges later; outputs
//   are compared every cycle. Directed phases check the documented impulse,
//   saturation, bubble, rounding, coefficient-update and reset scenarios.
module tb_fir_param_pipe;

  localparam int TAPS = 16;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int FRAC = 15;
  localparam int LAT  = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic          flush = 1'b0;
  logic          coef_wr = 1'b0;
  logic [3:0]    coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          out_valid;
  logic [DW-1:0] y_out;
  logic          sat_flag;

  always #5 clk = ~clk;

  fir_param_pipe #(
    .TAPS (TAPS),
    .DW   (DW),
    .CW   (CW),
    .FRAC (FRAC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .flush     (flush),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .y_out     (y_out),
    .sat_flag  (sat_flag)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;

  longint m_hist [TAPS];
  longint m_coef [TAPS];
  bit     ev [64];
  longint ey [64];
  bit     es [64];
  longint hold_y = 0;
  bit     hold_s = 1'b0;
  bit     exp_v;
  longint obs_y [64];

  bit     collect = 1'b0;
  longint got_q [$];
  int     first_edge = 0;

  longint imp_coef [16] = '{512, 1024, 2048, 4096, 8192, 4096, 2048, 1024,
                            512, 256, 128, 64, 32, 16, 8, 4};
  longint imp_exp  [16] = '{256, 512, 1024, 2048, 4096, 2048, 1024, 512,
                            256, 128, 64, 32, 16, 8, 4, 2};

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference output for the current history: dot product, scale, clip.
  function automatic void ref_out(output longint y, output bit s);
    longint acc;
    longint sc;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += m_hist[i] * m_coef[i];
`ifdef FIR_ROUND_EN
    sc = (acc + 16384) >>> FRAC;
`else
    sc = acc >>> FRAC;
`endif
    if (sc > 32767) begin y = 32767; s = 1'b1; end
    else if (sc < -32768) begin y = -32768; s = 1'b1; end
    else begin y = sc; s = 1'b0; end
  endfunction

  task automatic model_edge(input bit rs, input bit fl, input bit iv, input longint x,
                            input bit wr, input int addr, input longint data);
    int slot;
    int sl;
    longint y;
    bit s;
    slot = cyc % 64;
    if (rs) begin
      for (int i = 0; i < TAPS; i++) begin m_hist[i] = 0; m_coef[i] = 0; end
      for (int j = 0; j < 64; j++) ev[j] = 1'b0;
      hold_y = 0;
      hold_s = 1'b0;
    end else begin
      if (wr) m_coef[addr] = data;
      if (fl) begin
        for (int i = 0; i < TAPS; i++) m_hist[i] = 0;
        for (int j = 0; j < 64; j++) ev[j] = 1'b0;
      end else if (iv) begin
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = x;
        ref_out(y, s);
        sl = (cyc + LAT - 1) % 64;
        ev[sl] = 1'b1;
        ey[sl] = y;
        es[sl] = s;
      end
    end
    if (ev[slot]) begin
      hold_y = ey[slot];
      hold_s = es[slot];
    end
    exp_v = ev[slot];
    ev[slot] = 1'b0;
  endtask

  // One clock: drive, let the edge happen, update the model, check at negedge.
  task automatic do_cycle(input bit rs, input bit fl, input bit iv, input longint x,
                          input bit wr, input int addr, input longint data);
    rst       = rs;
    flush     = fl;
    in_valid  = iv;
    x_in      = 16'(x);
    coef_wr   = wr;
    coef_addr = 4'(addr);
    coef_data = 16'(data);
    @(posedge clk);
    cyc++;
    model_edge(rs, fl, iv, x, wr, addr, data);
    @(negedge clk);
    check_val("out_valid", longint'(out_valid), longint'(exp_v));
    check_val("y_out", longint'($signed(y_out)), hold_y);
    check_val("sat_flag", longint'(sat_flag), longint'(hold_s));
    obs_y[cyc % 64] = longint'($signed(y_out));
    if (collect && out_valid) begin
      if (got_q.size() == 0) first_edge = cyc;
      got_q.push_back(longint'($signed(y_out)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    int imp_edge;
    int t;
    longint exp_r;
    for (int i = 0; i < TAPS; i++) begin m_hist[i] = 0; m_coef[i] = 0; end
    for (int j = 0; j < 64; j++) begin ev[j] = 1'b0; ey[j] = 0; es[j] = 1'b0; obs_y[j] = 0; end

    @(negedge clk);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    check_val("rst_y", longint'($signed(y_out)), 0);
    check_val("rst_valid", longint'(out_valid), 0);

    // Impulse, dense stream.
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, i, imp_coef[i]);
    got_q.delete();
    collect = 1'b1;
    do_cycle(1'b0, 1'b0, 1'b1, 16384, 1'b0, 0, 0);
    imp_edge = cyc;
    for (int i = 0; i < 24; i++) do_cycle(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 0);
    idle(8);
    collect = 1'b0;
    check_val("imp_count", longint'(got_q.size()), 25);
    check_val("imp_latency", longint'(first_edge), longint'(imp_edge + LAT - 1));
    for (int i = 0; i < 25; i++) begin
      exp_r = (i < 16) ? imp_exp[i] : 0;
      if (i < got_q.size()) check_val("imp_y", got_q[i], exp_r);
    end

    // Impulse with bubbles: valid every third cycle.
    do_cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    got_q.delete();
    collect = 1'b1;
    for (int n = 0; n < 48; n++) begin
      do_cycle(1'b0, 1'b0, (n % 3) == 0, (n == 0) ? 16384 : 0, 1'b0, 0, 0);
    end
    idle(8);
    collect = 1'b0;
    check_val("bub_count", longint'(got_q.size()), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size()) check_val("bub_y", got_q[i], imp_exp[i]);
    end

    // Saturation, both rails.
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, i, 32767);
    for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b0, 1'b1, 32767, 1'b0, 0, 0);
    check_val("sat_pos_y", longint'($signed(y_out)), 32767);
    check_val("sat_pos_flag", longint'(sat_flag), 1);
    for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b0, 1'b1, -32768, 1'b0, 0, 0);
    check_val("sat_neg_y", longint'($signed(y_out)), -32768);
    check_val("sat_neg_flag", longint'(sat_flag), 1);

    // Rounding: 16384 * 1 >> 15 is exactly one half.
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, i, (i == 0) ? 16384 : 0);
    do_cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 0);
`ifdef FIR_ROUND_EN
    check_val("round_y", longint'($signed(y_out)), 1);
`else
    check_val("round_y", longint'($signed(y_out)), 0);
`endif
    check_val("round_flag", longint'(sat_flag), 0);

    // Coefficient update mid-stream, then flush.
    do_cycle(1'b0, 1'b0, 1'b1, 1000, 1'b1, 0, 8192);
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b0, 1'b1, 1000, 1'b0, 0, 0);
    check_val("coef_old_y", longint'($signed(y_out)), 250);
    do_cycle(1'b0, 1'b0, 1'b1, 1000, 1'b1, 0, 16384);
    t = cyc;
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 1'b1, 1000, 1'b0, 0, 0);
    check_val("coef_step_before", obs_y[(t + 5) % 64], 250);
    check_val("coef_step_after", obs_y[(t + 6) % 64], 500);
    do_cycle(1'b0, 1'b1, 1'b1, 1000, 1'b0, 0, 0);
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b0, 1'b1, 1000, 1'b0, 0, 0);

    // Random stream with writes, flushes and one mid-stream reset.
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, i, longint'($urandom_range(0, 8191)) - 4096);
    end
    for (int n = 0; n < 400; n++) begin
      do_cycle(n == 200, (n % 97) == 50, $urandom_range(0, 3) != 0,
               longint'($urandom_range(0, 65535)) - 32768,
               $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0) ? longint'($urandom_range(0, 65535)) - 32768
                                           : longint'($urandom_range(0, 8191)) - 4096);
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
